nco_sample_capture: RTL and testbench

NCO_SAMPLE_CAPTURE -- requirements
Module: nco_sample_capture

---
 rtl/nco_capture_pkg.sv | 18 +
 rtl/nco_sample_capture.sv | 132 +++++++++++++
 tb/tb_nco_sample_capture.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/nco_capture_pkg.sv
// Shared types and word layout for the NCO sample capture block.
// Each memory word packs sine in the upper half and cosine in the lower half.
package nco_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  localparam int SAMPLE_W     = 18;
  localparam int MEM_DATA_W   = 64;
  localparam int WORD_HALF_W  = 32;
  localparam int WORD_SIN_LSB = 32;
  localparam int WORD_COS_LSB = 0;

endpackage

// File: rtl/nco_sample_capture.sv
// Captures decimated NCO sine/cosine pairs into on-chip memory after a trigger.
// Arm latches length/decimation; abort or reset cancels with no further writes.
module nco_sample_capture #(
  parameter int ADDR_W   = 14,
  parameter int SAMPLE_W = nco_capture_pkg::SAMPLE_W
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [2*SAMPLE_W-1:0] nco_out_data,
  input  logic                  nco_out_valid,
  input  logic                  ctrl_arm,
  input  logic                  ctrl_abort,
  input  logic                  ext_trigger,
  input  logic [ADDR_W-1:0]     ctrl_length,
  input  logic [7:0]            ctrl_decim,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_clken,
  output logic                  mem_write,
  output logic [63:0]           mem_writedata,
  output logic [7:0]            mem_byteenable,
  output logic                  status_busy,
  output logic                  status_done,
  output logic [ADDR_W:0]       status_count
);

  import nco_capture_pkg::*;

  localparam int CW = ADDR_W + 1;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_len;
  logic [ADDR_W-1:0]     r_next_addr;
  logic [ADDR_W-1:0]     r_addr;
  logic [7:0]            r_decim;
  logic [7:0]            r_dcnt;
  logic [CW-1:0]         r_count;
  logic                  r_wr;
  logic [MEM_DATA_W-1:0] r_wdata;

  logic [SAMPLE_W-1:0]   w_sin;
  logic [SAMPLE_W-1:0]   w_cos;
  logic [MEM_DATA_W-1:0] w_word;
  logic [CW-1:0]         w_target;
  logic                  w_keep;
  logic                  w_last;

  assign w_sin = nco_out_data[2*SAMPLE_W-1:SAMPLE_W];
  assign w_cos = nco_out_data[SAMPLE_W-1:0];

  assign w_word[WORD_SIN_LSB +: WORD_HALF_W] =
    {{(WORD_HALF_W-SAMPLE_W){w_sin[SAMPLE_W-1]}}, w_sin};
  assign w_word[WORD_COS_LSB +: WORD_HALF_W] =
    {{(WORD_HALF_W-SAMPLE_W){w_cos[SAMPLE_W-1]}}, w_cos};

  // A zero length means the full address space.
  assign w_target = (r_len == '0) ? (CW'(1) << ADDR_W)
                                  : {1'b0, r_len};
  assign w_last   = (r_count + CW'(1)) == w_target;

  // The trigger cycle's own sample is the first kept sample.
  assign w_keep = nco_out_valid && !ctrl_abort &&
    ((r_state == ARMED && ext_trigger) ||
     (r_state == CAPTURE && r_dcnt == 8'd0));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_decim     <= '0;
      r_dcnt      <= '0;
      r_next_addr <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_wr <= w_keep;
      if (w_keep) begin
        r_wdata     <= w_word;
        r_addr      <= r_next_addr;
        r_next_addr <= r_next_addr + ADDR_W'(1);
        r_count     <= r_count + CW'(1);
      end
      unique case (r_state)
        IDLE, DONE: begin
          if (ctrl_arm) begin
            r_len       <= ctrl_length;
            r_decim     <= ctrl_decim;
            r_dcnt      <= '0;
            r_count     <= '0;
            r_next_addr <= '0;
            r_addr      <= '0;
            r_state     <= ARMED;
          end
        end
        ARMED: begin
          if (ctrl_abort) begin
            r_state <= IDLE;
          end else if (ext_trigger) begin
            r_dcnt  <= (nco_out_valid && r_decim != 8'd0)
                       ? 8'd1 : 8'd0;
            r_state <= (w_keep && w_last) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (ctrl_abort) begin
            r_state <= IDLE;
          end else begin
            if (nco_out_valid)
              r_dcnt <= (r_dcnt == r_decim) ? 8'd0
                                            : r_dcnt + 8'd1;
            if (w_keep && w_last)
              r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_address    = r_addr;
  assign mem_write      = r_wr;
  assign mem_chipselect = r_wr;
  assign mem_byteenable = r_wr ? 8'hFF : 8'h00;
  assign mem_writedata  = r_wdata;
  assign mem_clken      = 1'b1;
  assign status_busy    = (r_state == ARMED) || (r_state == CAPTURE);
  assign status_done    = (r_state == DONE);
  assign status_count   = r_count;

endmodule

// File: tb/tb_nco_sample_capture.sv
// Directed bench for nco_sample_capture: per-cycle vector table plus
// hand sequences for full-length, abort priority and mid-capture reset.
module tb_nco_sample_capture;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [35:0] nco_out_data;
  logic        nco_out_valid;
  logic        ctrl_arm;
  logic        ctrl_abort;
  logic        ext_trigger;
  logic [13:0] ctrl_length;
  logic [7:0]  ctrl_decim;
  logic [13:0] mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic [7:0]  mem_byteenable;
  logic        status_busy;
  logic        status_done;
  logic [14:0] status_count;

  nco_sample_capture dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .nco_out_data   (nco_out_data),
    .nco_out_valid  (nco_out_valid),
    .ctrl_arm       (ctrl_arm),
    .ctrl_abort     (ctrl_abort),
    .ext_trigger    (ext_trigger),
    .ctrl_length    (ctrl_length),
    .ctrl_decim     (ctrl_decim),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .status_busy    (status_busy),
    .status_done    (status_done),
    .status_count   (status_count)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    string       tag;
    logic        arm, abort, trig, valid;
    logic [17:0] sin, cos;
    logic [13:0] len;
    logic [7:0]  decim;
    logic        e_wr;
    logic [13:0] e_addr;
    logic [63:0] e_data;
    logic        e_busy, e_done;
    logic [14:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] D039 = 64'h0001FFFF_FFFE0000;

  function automatic void add(
    input string t,
    input logic arm, abort, trig, valid,
    input logic [17:0] s, c,
    input logic [13:0] len, input logic [7:0] dec,
    input logic wr, input logic [13:0] a, input logic [63:0] d,
    input logic busy, done, input logic [14:0] cnt);
    vec_t v;
    v.tag = t; v.arm = arm; v.abort = abort; v.trig = trig;
    v.valid = valid; v.sin = s; v.cos = c; v.len = len;
    v.decim = dec; v.e_wr = wr; v.e_addr = a; v.e_data = d;
    v.e_busy = busy; v.e_done = done; v.e_cnt = cnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string t, input logic wr,
                         input logic [13:0] a, input logic busy,
                         input logic done, input logic [14:0] cnt);
    chk({t, "_wr"}, mem_write, wr);
    chk({t, "_cs"}, mem_chipselect, wr);
    chk({t, "_be"}, mem_byteenable, wr ? 8'hFF : 8'h00);
    chk({t, "_clken"}, mem_clken, 1'b1);
    chk({t, "_addr"}, mem_address, a);
    chk({t, "_busy"}, status_busy, busy);
    chk({t, "_done"}, status_done, done);
    chk({t, "_cnt"}, status_count, cnt);
  endtask

  task automatic drive(input logic arm, abort, trig, valid,
                       input logic [17:0] s, c,
                       input logic [13:0] len, input logic [7:0] dec);
    ctrl_arm      = arm;
    ctrl_abort    = abort;
    ext_trigger   = trig;
    nco_out_valid = valid;
    nco_out_data  = {s, c};
    ctrl_length   = len;
    ctrl_decim    = dec;
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    int nwr, bad;
    logic [13:0] last_a;

    // Idle trigger ignored, length-4 capture with an ignored re-arm.
    add("idle_trig", 0,0,1,1, 18'h1FFFF,18'h20000, 14'd0,8'd0,
        0,14'd0,64'd0, 0,0,15'd0);
    add("arm4",      1,0,0,0, 18'h0,18'h0, 14'd4,8'd0,
        0,14'd0,64'd0, 1,0,15'd0);
    add("trig4",     0,0,1,0, 18'h0,18'h0, 14'd0,8'd0,
        0,14'd0,64'd0, 1,0,15'd0);
    add("w0",        0,0,0,1, 18'h1FFFF,18'h20000, 14'd0,8'd0,
        1,14'd0,D039, 1,0,15'd1);
    add("w1_rearm",  1,0,0,1, 18'h1FFFF,18'h20000, 14'd1,8'd3,
        1,14'd1,D039, 1,0,15'd2);
    add("w2",        0,0,0,1, 18'h1FFFF,18'h20000, 14'd0,8'd0,
        1,14'd2,D039, 1,0,15'd3);
    add("w3",        0,0,0,1, 18'h1FFFF,18'h20000, 14'd0,8'd0,
        1,14'd3,D039, 0,1,15'd4);
    add("done_ign",  0,0,0,1, 18'h1FFFF,18'h20000, 14'd0,8'd0,
        0,14'd3,64'd0, 0,1,15'd4);
    // Length 3, keep one in three.
    add("arm3d2",    1,0,0,0, 18'h0,18'h0, 14'd3,8'd2,
        0,14'd0,64'd0, 1,0,15'd0);
    add("trig3",     0,0,1,0, 18'h0,18'h0, 14'd0,8'd0,
        0,14'd0,64'd0, 1,0,15'd0);
    add("s0", 0,0,0,1, 18'h1,18'h0, 14'd0,8'd0,
        1,14'd0,64'h00000001_00000000, 1,0,15'd1);
    add("s1", 0,0,0,1, 18'h2,18'h1, 14'd0,8'd0,
        0,14'd0,64'd0, 1,0,15'd1);
    add("s2", 0,0,0,1, 18'h3,18'h2, 14'd0,8'd0,
        0,14'd0,64'd0, 1,0,15'd1);
    add("s3", 0,0,0,1, 18'h3FFFD,18'h3, 14'd0,8'd0,
        1,14'd1,64'hFFFFFFFD_00000003, 1,0,15'd2);
    add("s4", 0,0,0,1, 18'h5,18'h4, 14'd0,8'd0,
        0,14'd1,64'd0, 1,0,15'd2);
    add("s5", 0,0,0,1, 18'h6,18'h5, 14'd0,8'd0,
        0,14'd1,64'd0, 1,0,15'd2);
    add("s6", 0,0,0,1, 18'h6,18'h3FFFA, 14'd0,8'd0,
        1,14'd2,64'h00000006_FFFFFFFA, 0,1,15'd3);
    add("s7", 0,0,0,1, 18'h8,18'h7, 14'd0,8'd0,
        0,14'd2,64'd0, 0,1,15'd3);
    add("s8", 0,0,0,1, 18'h9,18'h8, 14'd0,8'd0,
        0,14'd2,64'd0, 0,1,15'd3);

    reset_reset = 1'b1;
    drive(0,0,0,0, 18'h0,18'h0, 14'd0,8'd0);
    drive(0,0,0,1, 18'h1FFFF,18'h1, 14'd5,8'd1);
    chk_out("reset", 0, 14'd0, 0, 0, 15'd0);
    chk("reset_data", mem_writedata, 64'd0);
    reset_reset = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      vec_t v;
      v = tbl[k];
      drive(v.arm, v.abort, v.trig, v.valid, v.sin, v.cos,
            v.len, v.decim);
      chk_out(v.tag, v.e_wr, v.e_addr, v.e_busy, v.e_done, v.e_cnt);
      if (v.e_wr) chk({v.tag, "_data"}, mem_writedata, v.e_data);
    end

    // Abort after two of five writes; trigger+valid is the first keep.
    drive(1,0,0,0, 18'h0,18'h0, 14'd5,8'd0);
    drive(0,0,1,1, 18'h5,18'h5, 14'd0,8'd0);
    chk_out("ab_w0", 1, 14'd0, 1, 0, 15'd1);
    chk("ab_w0_data", mem_writedata, 64'h00000005_00000005);
    drive(0,0,0,1, 18'h6,18'h6, 14'd0,8'd0);
    chk_out("ab_w1", 1, 14'd1, 1, 0, 15'd2);
    drive(0,1,0,1, 18'h7,18'h7, 14'd0,8'd0);
    chk_out("ab_abort", 0, 14'd1, 0, 0, 15'd2);
    drive(0,0,1,1, 18'h8,18'h8, 14'd0,8'd0);
    chk_out("ab_after", 0, 14'd1, 0, 0, 15'd2);

    // Abort beats trigger, and beats the final write.
    drive(1,0,0,0, 18'h0,18'h0, 14'd5,8'd0);
    drive(0,1,1,1, 18'h9,18'h9, 14'd0,8'd0);
    chk_out("ab_vs_trig", 0, 14'd0, 0, 0, 15'd0);
    drive(1,0,0,0, 18'h0,18'h0, 14'd1,8'd0);
    drive(0,1,1,1, 18'hA,18'hA, 14'd0,8'd0);
    chk_out("ab_vs_last", 0, 14'd0, 0, 0, 15'd0);

    // Length 1 finishes straight from the trigger cycle.
    drive(1,0,0,0, 18'h0,18'h0, 14'd1,8'd0);
    drive(0,0,1,1, 18'h3FFFF,18'h1, 14'd0,8'd0);
    chk_out("len1", 1, 14'd0, 0, 1, 15'd1);
    chk("len1_data", mem_writedata, 64'hFFFFFFFF_00000001);

    // Length 0 covers the whole address space.
    drive(1,0,0,0, 18'h0,18'h0, 14'd0,8'd0);
    drive(0,0,1,0, 18'h0,18'h0, 14'd0,8'd0);
    nwr = 0; bad = 0; last_a = '0;
    for (int i = 0; i < 16400; i++) begin
      drive(0,0,0,1, 18'(i),18'(i), 14'd0,8'd0);
      if (mem_write) begin
        if (mem_address !== 14'(nwr)) bad++;
        last_a = mem_address;
        nwr++;
      end
    end
    chk("len0_writes", 64'(nwr), 64'd16384);
    chk("len0_addr_seq", 64'(bad), 64'd0);
    chk("len0_last_addr", last_a, 14'd16383);
    chk("len0_cnt", status_count, 15'd16384);
    chk("len0_done", status_done, 1'b1);

    // Reset in the cycle of a kept sample.
    drive(1,0,0,0, 18'h0,18'h0, 14'd4,8'd0);
    drive(0,0,1,0, 18'h0,18'h0, 14'd0,8'd0);
    drive(0,0,0,1, 18'h11,18'h22, 14'd0,8'd0);
    chk_out("rst_pre", 1, 14'd0, 1, 0, 15'd1);
    reset_reset = 1'b1;
    drive(0,0,0,1, 18'h33,18'h44, 14'd0,8'd0);
    chk_out("rst_mid", 0, 14'd0, 0, 0, 15'd0);
    chk("rst_mid_data", mem_writedata, 64'd0);
    reset_reset = 1'b0;
    drive(0,0,0,1, 18'h55,18'h66, 14'd0,8'd0);
    chk_out("rst_post", 0, 14'd0, 0, 0, 15'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
